led_shift_driver: RTL

- Downstream stage of the bound flasher.
- Takes the 16-bit LED pattern and mirrors it onto an external daisy chain of two 8-bit serial-in/parallel-out latching shift registers, using a serial clock, serial data and a latch strobe.
- Sends a frame only when the pattern differs from the last frame sent, plus one forced frame after every reset release.
- Single clock domain, same clock as the flasher.

---
 rtl/bound_flasher_pkg.sv | 14 +
 rtl/serial_phase_gen.sv | 42 ++++
 rtl/led_shift_driver.sv | 100 ++++++++++
 3 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared types and constants for the bound flasher and its LED shift-register driver.
package bound_flasher_pkg;

  localparam int unsigned LED_WIDTH       = 16;
  localparam int unsigned DEFAULT_CLK_DIV = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } shift_state_t;

endpackage

// File: rtl/serial_phase_gen.sv
// Serial clock phase generator: CLK_DIV clk cycles per phase, strobes at the end of each phase.
module serial_phase_gen
  import bound_flasher_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic hold_low,
  output logic phase,
  output logic end_low,
  output logic end_high
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap     = (div_cnt == DIV_LAST);
  assign end_low  = run & ~phase & wrap;
  assign end_high = run &  phase & wrap;

  // hold_low keeps counting phases without raising the clock (used as the latch timer)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      if (!hold_low) phase <= ~phase;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_shift_driver.sv
// Mirrors the LED pattern onto a chain of latching serial-in/parallel-out shift registers,
// sending a frame only when the pattern changes (plus one forced frame after reset).
module led_shift_driver
  import bound_flasher_pkg::*;
#(
  parameter int unsigned WIDTH     = LED_WIDTH,
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] led_in,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  shift_state_t     state, state_next;
  logic [WIDTH-1:0] shadow, last_sent, shadow_shifted;
  logic [CNT_W-1:0] bit_cnt;
  logic             force_refresh;
  logic             rel_sync;
  logic             end_low, end_high;
  logic             first_bit, next_bit;

  serial_phase_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_phase (
    .clk     (clk),
    .reset   (reset),
    .run     ((state == SHIFT) || (state == LATCH)),
    .hold_low(state == LATCH),
    .phase   (sclk),
    .end_low (end_low),
    .end_high(end_high)
  );

  assign shadow_shifted = MSB_FIRST ? (shadow << 1) : (shadow >> 1);
  assign next_bit       = MSB_FIRST ? shadow_shifted[WIDTH-1] : shadow_shifted[0];
  assign first_bit      = MSB_FIRST ? led_in[WIDTH-1] : led_in[0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rel_sync && ((led_in != last_sent) || force_refresh)) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (end_high && (bit_cnt == '0)) state_next = LATCH;
      LATCH:   if (end_low) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from state_next so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rel_sync      <= 1'b0;
      force_refresh <= 1'b1;
      shadow        <= '0;
      last_sent     <= '0;
      bit_cnt       <= '0;
      sdata         <= 1'b0;
      slatch        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      rel_sync   <= 1'b1;
      state      <= state_next;
      busy       <= (state_next != IDLE);
      slatch     <= (state_next == LATCH);
      frame_done <= (state == LATCH) && (state_next == IDLE);
      case (state)
        LOAD: begin
          shadow        <= led_in;
          last_sent     <= led_in;
          force_refresh <= 1'b0;
          bit_cnt       <= BIT_LAST;
          sdata         <= first_bit;
        end
        SHIFT: begin
          if (end_high && (bit_cnt != '0)) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            shadow  <= shadow_shifted;
            sdata   <= next_bit;
          end
        end
        LATCH: begin
          if (end_low) sdata <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
